// File: rtl/apb_master.sv
// APB initiator bridging the core's single-request load/store port to up to
// NUM_SLAVES peripherals. One transfer in flight at a time; a wait-state
// timeout completes the transfer with an error if the slave never answers.
module apb_master #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_LSB    = 12,
    parameter logic [15:0] BASE_HI    = 16'h4000,
    parameter int          TIMEOUT    = 16
) (
    input  logic                       PCLK,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic                       cpu_write,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic                       cpu_busy,
    output logic                       cpu_done,
    output logic [31:0]                cpu_rdata,
    output logic                       cpu_err,
    output logic [31:0]                PADDR,
    output logic                       PWRITE,
    output logic [31:0]                PWDATA,
    output logic [NUM_SLAVES-1:0]      PSEL,
    output logic                       PENABLE,
    input  logic [32*NUM_SLAVES-1:0]   PRDATA,
    input  logic [NUM_SLAVES-1:0]      PREADY,
    input  logic [NUM_SLAVES-1:0]      PSLVERR
);

    // Slave index field width; NUM_SLAVES is expected to be a power of two.
    localparam int         IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_DERR   = 3'd4;

    logic [2:0]            state_reg,   state_next;
    logic [7:0]            cnt_reg,     cnt_next;
    logic [31:0]           paddr_reg,   paddr_next;
    logic [31:0]           pwdata_reg,  pwdata_next;
    logic                  pwrite_reg,  pwrite_next;
    logic [NUM_SLAVES-1:0] psel_reg,    psel_next;
    logic                  penable_reg, penable_next;
    logic                  done_reg,    done_next;
    logic                  err_reg,     err_next;
    logic [31:0]           rdata_reg,   rdata_next;

    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic [NUM_SLAVES-1:0] req_dec;
    logic [31:0]           prdata_arr [NUM_SLAVES];
    logic                  sel_ready;
    logic                  sel_slverr;
    logic [31:0]           sel_prdata;
    logic                  addr_ok;

    // Index of the incoming request and of the transfer in flight.
    assign req_idx = cpu_addr[SEL_LSB +: IDX_W];
    assign sel_idx = paddr_reg[SEL_LSB +: IDX_W];
    assign addr_ok = (cpu_addr[31:16] == BASE_HI);

    // Per-slave read data slices and one-hot select decode of the request.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign prdata_arr[gi] = PRDATA[32*gi +: 32];
            assign req_dec[gi]    = (req_idx == IDX_W'(gi));
        end
    endgenerate

    // Only the selected slave's handshake and data are observed.
    assign sel_ready  = PREADY[sel_idx];
    assign sel_slverr = PSLVERR[sel_idx];
    assign sel_prdata = prdata_arr[sel_idx];

    // Next-state and next-output logic for the transfer sequence.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        pwrite_next  = pwrite_reg;
        psel_next    = psel_reg;
        penable_next = penable_reg;
        done_next    = 1'b0;
        err_next     = err_reg;
        rdata_next   = rdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (cpu_req) begin
                    paddr_next  = cpu_addr;
                    pwdata_next = cpu_wdata;
                    pwrite_next = cpu_write;
                    if (addr_ok) begin
                        state_next = S_SETUP;
                        psel_next  = req_dec;
                        cnt_next   = 8'd0;
                    end else begin
                        // Outside the peripheral window: no bus cycle at all.
                        state_next = S_DERR;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        rdata_next = 32'd0;
                    end
                end
            end
            S_SETUP: begin
                state_next   = S_ACCESS;
                penable_next = 1'b1;
            end
            S_ACCESS: begin
                if (sel_ready) begin
                    state_next   = S_DONE;
                    psel_next    = '0;
                    penable_next = 1'b0;
                    done_next    = 1'b1;
                    err_next     = sel_slverr;
                    rdata_next   = pwrite_reg ? 32'd0 : sel_prdata;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    if (cnt_reg + 8'd1 == TIMEOUT_LIM) begin
                        // Slave is hung: abort and report an error.
                        state_next   = S_DONE;
                        psel_next    = '0;
                        penable_next = 1'b0;
                        done_next    = 1'b1;
                        err_next     = 1'b1;
                        rdata_next   = 32'd0;
                    end
                end
            end
            S_DONE, S_DERR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next   = S_IDLE;
                psel_next    = '0;
                penable_next = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 8'd0;
            paddr_reg   <= 32'd0;
            pwdata_reg  <= 32'd0;
            pwrite_reg  <= 1'b0;
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= 32'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            pwrite_reg  <= pwrite_next;
            psel_reg    <= psel_next;
            penable_reg <= penable_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            rdata_reg   <= rdata_next;
        end
    end

    assign cpu_busy  = (state_reg != S_IDLE);
    assign cpu_done  = done_reg;
    assign cpu_rdata = rdata_reg;
    assign cpu_err   = err_reg;
    assign PADDR     = paddr_reg;
    assign PWRITE    = pwrite_reg;
    assign PWDATA    = pwdata_reg;
    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;

endmodule
